// File: rtl/axis_packet_parser_if.sv
// AXI-stream bundle shared by the parser's ingress and egress ports.
// tdest is only meaningful on the egress side; ingress drivers tie it to zero.
interface axis_packet_parser_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned USER_W = 16,
   parameter int unsigned DEST_W = 5
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic [USER_W-1:0] tuser;
   logic              tlast;
   logic [DEST_W-1:0] tdest;

   modport master (output tvalid, tdata, tuser, tlast, tdest, input tready);
   modport slave  (input tvalid, tdata, tuser, tlast, tdest, output tready);
endinterface

// File: rtl/axis_packet_parser.sv
// Validates each ingress packet against the connection table, strips the header beat and
// forwards the payload tagged with its output port. Optional macro: PARSER_DROP_CNT_EN.
module axis_packet_parser #(
   parameter int unsigned AXIS_DATA_SIZE = 32,
   parameter int unsigned USER_SIZE      = 16,
   parameter int unsigned CFG_ADDR_SIZE  = 15,
   parameter int unsigned DATA_SIZE      = 32,
   parameter int unsigned PORT_SIZE      = 5
) (
   input  logic                     clk,
   input  logic                     reset_n,
   axis_packet_parser_if.slave      s_axis,
   axis_packet_parser_if.master     m_axis,
   output logic                     cfg_rd_en_o,
   output logic [CFG_ADDR_SIZE-1:0] cfg_rd_addr_o,
   input  logic [DATA_SIZE-1:0]     cfg_rd_data_i,
   output logic                     drop_pulse_o
`ifdef PARSER_DROP_CNT_EN
   ,
   output logic [15:0]              drop_cnt_o
`endif
);

   typedef enum logic [2:0] {StIdle, StLookup, StCheck, StFwd, StDrop} state_e;

   state_e               state_q, state_d;
   logic                 active_q;
   logic [7:0]           len_q, len_d;
   logic                 hdr_last_q, hdr_last_d;
   logic                 cfg_valid_q, cfg_valid_d;
   logic [PORT_SIZE-1:0] cfg_port_q, cfg_port_d;
   logic [PORT_SIZE-1:0] dest_q, dest_d;
   logic [7:0]           cnt_q, cnt_d;
   logic                 at_len;
   logic                 unused_bits;

   assign unused_bits = ^{cfg_rd_data_i[DATA_SIZE-2:PORT_SIZE], s_axis.tdest};
   // len is never 0 in StFwd, so the decrement cannot wrap there.
   assign at_len      = (cnt_q == len_q - 8'd1);
   assign m_axis.tdest = dest_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         active_q    <= 1'b0;
         len_q       <= '0;
         hdr_last_q  <= 1'b0;
         cfg_valid_q <= 1'b0;
         cfg_port_q  <= '0;
         dest_q      <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         active_q    <= 1'b1;
         len_q       <= len_d;
         hdr_last_q  <= hdr_last_d;
         cfg_valid_q <= cfg_valid_d;
         cfg_port_q  <= cfg_port_d;
         dest_q      <= dest_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      hdr_last_d    = hdr_last_q;
      cfg_valid_d   = cfg_valid_q;
      cfg_port_d    = cfg_port_q;
      dest_d        = dest_q;
      cnt_d         = cnt_q;
      s_axis.tready = 1'b0;
      m_axis.tvalid = 1'b0;
      m_axis.tdata  = '0;
      m_axis.tuser  = '0;
      m_axis.tlast  = 1'b0;
      cfg_rd_en_o   = 1'b0;
      cfg_rd_addr_o = '0;
      drop_pulse_o  = 1'b0;
      unique case (state_q)
         StIdle: begin
            // active_q keeps s_tready low while reset is held.
            s_axis.tready = active_q;
            if (s_axis.tvalid && active_q) begin
               cfg_rd_en_o   = 1'b1;
               cfg_rd_addr_o = s_axis.tdata[CFG_ADDR_SIZE-1:0];
               len_d         = s_axis.tdata[31:24];
               hdr_last_d    = s_axis.tlast;
               state_d       = StLookup;
            end
         end
         StLookup: begin
            cfg_valid_d = cfg_rd_data_i[DATA_SIZE-1];
            cfg_port_d  = cfg_rd_data_i[PORT_SIZE-1:0];
            state_d     = StCheck;
         end
         StCheck: begin
            if (!cfg_valid_q || (len_q == 8'd0) || hdr_last_q) begin
               drop_pulse_o = 1'b1;
               state_d      = hdr_last_q ? StIdle : StDrop;
            end else begin
               dest_d  = cfg_port_q;
               cnt_d   = 8'd0;
               state_d = StFwd;
            end
         end
         StFwd: begin
            m_axis.tvalid = s_axis.tvalid;
            s_axis.tready = m_axis.tready;
            m_axis.tdata  = s_axis.tdata;
            m_axis.tuser  = s_axis.tuser;
            m_axis.tlast  = at_len | s_axis.tlast;
            // Short or long packet: tag the closing beat as errored.
            if (at_len != s_axis.tlast) m_axis.tuser[0] = 1'b1;
            if (s_axis.tvalid && m_axis.tready) begin
               if (s_axis.tlast || at_len) begin
                  drop_pulse_o = (at_len != s_axis.tlast);
                  state_d      = s_axis.tlast ? StIdle : StDrop;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         StDrop: begin
            s_axis.tready = 1'b1;
            if (s_axis.tvalid && s_axis.tlast) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef PARSER_DROP_CNT_EN
   logic [15:0] drop_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_cnt_q <= '0;
      end else if (drop_pulse_o && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_axis_packet_parser.sv
// Directed bench for axis_packet_parser: table-driven packets against a small config RAM model.
module tb_axis_packet_parser;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cfg_rd_en;
   logic [14:0] cfg_rd_addr;
   logic [31:0] cfg_rd_data = 32'h0;
   logic        drop_pulse;
`ifdef PARSER_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   always #5 clk = ~clk;

   axis_packet_parser_if #(.DATA_W(32), .USER_W(16), .DEST_W(5)) s_if ();
   axis_packet_parser_if #(.DATA_W(32), .USER_W(16), .DEST_W(5)) m_if ();

   axis_packet_parser dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .s_axis        (s_if),
      .m_axis        (m_if),
      .cfg_rd_en_o   (cfg_rd_en),
      .cfg_rd_addr_o (cfg_rd_addr),
      .cfg_rd_data_i (cfg_rd_data),
      .drop_pulse_o  (drop_pulse)
`ifdef PARSER_DROP_CNT_EN
      ,
      .drop_cnt_o    (drop_cnt)
`endif
   );

   logic [31:0] cfg_mem [0:32767];
   always @(posedge clk) if (cfg_rd_en) cfg_rd_data <= cfg_mem[cfg_rd_addr];

   typedef struct packed {
      logic [31:0] data;
      logic [15:0] user;
      logic        last;
      logic [4:0]  dest;
      logic        drop;
   } eg_t;

   eg_t         eg_q[$];
   int          drops = 0;
   int          cyc = 0;
   logic [14:0] last_rd_addr = '0;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          timeouts = 0;
   int          mirror_bad = 0;
   bit          mirror_en = 0;
   bit          tog = 1;
   int          last_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (m_if.tvalid && m_if.tready)
         eg_q.push_back('{m_if.tdata, m_if.tuser, m_if.tlast, m_if.tdest, drop_pulse});
      if (drop_pulse) drops <= drops + 1;
      if (cfg_rd_en) last_rd_addr <= cfg_rd_addr;
   end

   function automatic logic [31:0] pay(input int id, input int i);
      return 32'hD000_0000 | 32'(id << 8) | 32'(i);
   endfunction

   function automatic logic [15:0] pusr(input int i);
      return 16'(32'h0100 + 2 * i);
   endfunction

   // Holds one beat on the ingress side until accepted; tmode toggles m_tready each cycle.
   task automatic drive_beat(input logic [31:0] d, input logic [15:0] u, input logic l,
                             input bit tmode);
      bit done;
      done        = 0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tuser  = u;
      s_if.tlast  = l;
      for (int c = 0; c < 50 && !done; c++) begin
         if (tmode) begin
            m_if.tready = tog;
            tog = !tog;
         end else begin
            m_if.tready = 1'b1;
         end
         @(negedge clk);
         if (mirror_en && m_if.tvalid && (s_if.tready !== m_if.tready)) mirror_bad++;
         if (s_if.tready === 1'b1) begin
            done     = 1;
            last_acc = cyc;
         end
         @(posedge clk);
         #1;
      end
      if (!done) timeouts++;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b1;
   endtask

   task automatic send_pkt(input logic [7:0] len, input logic [14:0] id, input int nbeats,
                           input bit tmode);
      drive_beat({len, 9'd0, id}, 16'h0, nbeats == 0, 1'b0);
      for (int i = 1; i <= nbeats; i++) drive_beat(pay(int'(id), i), pusr(i), i == nbeats, tmode);
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'h0400_0005;
      s_if.tuser  = '0;
      s_if.tlast  = 1'b0;
      s_if.tdest  = '0;
      m_if.tready = 1'b1;
      #12;
      n_cmp++; if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL rst_s_tready: got %b want 0", s_if.tready); end
      n_cmp++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid: got %b want 0", m_if.tvalid); end
      n_cmp++; if (m_if.tdest !== 5'd0) begin n_fail++; $display("FAIL rst_m_tdest: got %0d want 0", m_if.tdest); end
      n_cmp++; if (cfg_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_rd_en: got %b want 0", cfg_rd_en); end
      n_cmp++; if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_drop_pulse: got %b want 0", drop_pulse); end
      s_if.tvalid = 1'b0;
      #10 reset_n = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL idle_s_tready: got %b want 1", s_if.tready); end
`ifdef PARSER_DROP_CNT_EN
      n_cmp++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
`endif
   endtask

   task automatic test_valid();
      int b; int d0;
      b = eg_q.size(); d0 = drops;
      send_pkt(8'd4, 15'd5, 4, 1'b0);
      settle();
      n_cmp++; if (last_rd_addr !== 15'd5) begin n_fail++; $display("FAIL valid_rd_addr: got %0d want 5", last_rd_addr); end
      n_cmp++; if (eg_q.size() - b !== 4) begin n_fail++; $display("FAIL valid_count: got %0d want 4", eg_q.size() - b); end
      for (int i = 0; i < 4 && b + i < eg_q.size(); i++) begin
         n_cmp++; if (eg_q[b+i].data !== pay(5, i + 1)) begin n_fail++; $display("FAIL valid_data[%0d]: got %h want %h", i, eg_q[b+i].data, pay(5, i + 1)); end
         n_cmp++; if (eg_q[b+i].user !== pusr(i + 1)) begin n_fail++; $display("FAIL valid_user[%0d]: got %h want %h", i, eg_q[b+i].user, pusr(i + 1)); end
         n_cmp++; if (eg_q[b+i].last !== (i == 3)) begin n_fail++; $display("FAIL valid_last[%0d]: got %b want %b", i, eg_q[b+i].last, i == 3); end
         n_cmp++; if (eg_q[b+i].dest !== 5'd3) begin n_fail++; $display("FAIL valid_dest[%0d]: got %0d want 3", i, eg_q[b+i].dest); end
      end
      n_cmp++; if (drops - d0 !== 0) begin n_fail++; $display("FAIL valid_drops: got %0d want 0", drops - d0); end
      n_cmp++; if (timeouts !== 0) begin n_fail++; $display("FAIL valid_timeouts: got %0d want 0", timeouts); end
   endtask

   task automatic test_invalid();
      int b; int d0;
      b = eg_q.size(); d0 = drops;
      send_pkt(8'd3, 15'd7, 3, 1'b0);
      settle();
      n_cmp++; if (eg_q.size() - b !== 0) begin n_fail++; $display("FAIL inv_count: got %0d want 0", eg_q.size() - b); end
      n_cmp++; if (drops - d0 !== 1) begin n_fail++; $display("FAIL inv_drops: got %0d want 1", drops - d0); end
      n_cmp++; if (timeouts !== 0) begin n_fail++; $display("FAIL inv_consumed: got %0d timeouts want 0", timeouts); end
      b = eg_q.size(); d0 = drops;
      send_pkt(8'd1, 15'd5, 1, 1'b0);
      settle();
      n_cmp++; if (eg_q.size() - b !== 1) begin n_fail++; $display("FAIL inv_next_count: got %0d want 1", eg_q.size() - b); end
      if (eg_q.size() > b) begin
         n_cmp++; if (eg_q[b].last !== 1'b1 || eg_q[b].dest !== 5'd3) begin n_fail++; $display("FAIL inv_next_beat: got last=%b dest=%0d want last=1 dest=3", eg_q[b].last, eg_q[b].dest); end
      end
      n_cmp++; if (drops - d0 !== 0) begin n_fail++; $display("FAIL inv_next_drops: got %0d want 0", drops - d0); end
      // Header carrying tlast, then a len=0 header with two trailing beats.
      b = eg_q.size(); d0 = drops;
      send_pkt(8'd4, 15'd5, 0, 1'b0);
      send_pkt(8'd0, 15'd5, 2, 1'b0);
      settle();
      n_cmp++; if (eg_q.size() - b !== 0) begin n_fail++; $display("FAIL hdr_len0_count: got %0d want 0", eg_q.size() - b); end
      n_cmp++; if (drops - d0 !== 2) begin n_fail++; $display("FAIL hdr_len0_drops: got %0d want 2", drops - d0); end
      n_cmp++; if (timeouts !== 0) begin n_fail++; $display("FAIL hdr_len0_timeouts: got %0d want 0", timeouts); end
   endtask

   task automatic test_short();
      int b; int d0;
      b = eg_q.size(); d0 = drops;
      send_pkt(8'd4, 15'd5, 2, 1'b0);
      settle();
      n_cmp++; if (eg_q.size() - b !== 2) begin n_fail++; $display("FAIL short_count: got %0d want 2", eg_q.size() - b); end
      if (eg_q.size() - b >= 2) begin
         n_cmp++; if (eg_q[b].last !== 1'b0 || eg_q[b].user !== pusr(1)) begin n_fail++; $display("FAIL short_beat1: got last=%b user=%h want last=0 user=%h", eg_q[b].last, eg_q[b].user, pusr(1)); end
         n_cmp++; if (eg_q[b+1].last !== 1'b1) begin n_fail++; $display("FAIL short_last: got %b want 1", eg_q[b+1].last); end
         n_cmp++; if (eg_q[b+1].user !== (pusr(2) | 16'h1)) begin n_fail++; $display("FAIL short_user: got %h want %h", eg_q[b+1].user, pusr(2) | 16'h1); end
         n_cmp++; if (eg_q[b+1].drop !== 1'b1) begin n_fail++; $display("FAIL short_drop_on_hs: got %b want 1", eg_q[b+1].drop); end
      end
      n_cmp++; if (drops - d0 !== 1) begin n_fail++; $display("FAIL short_drops: got %0d want 1", drops - d0); end
   endtask

   task automatic test_long();
      int b; int d0;
      b = eg_q.size(); d0 = drops;
      send_pkt(8'd2, 15'd5, 5, 1'b0);
      settle();
      n_cmp++; if (eg_q.size() - b !== 2) begin n_fail++; $display("FAIL long_count: got %0d want 2", eg_q.size() - b); end
      if (eg_q.size() - b >= 2) begin
         n_cmp++; if (eg_q[b].last !== 1'b0) begin n_fail++; $display("FAIL long_beat1_last: got %b want 0", eg_q[b].last); end
         n_cmp++; if (eg_q[b+1].last !== 1'b1 || eg_q[b+1].user !== (pusr(2) | 16'h1)) begin n_fail++; $display("FAIL long_beat2: got last=%b user=%h want last=1 user=%h", eg_q[b+1].last, eg_q[b+1].user, pusr(2) | 16'h1); end
         n_cmp++; if (eg_q[b+1].drop !== 1'b1) begin n_fail++; $display("FAIL long_drop_on_hs: got %b want 1", eg_q[b+1].drop); end
      end
      n_cmp++; if (drops - d0 !== 1) begin n_fail++; $display("FAIL long_drops: got %0d want 1", drops - d0); end
      n_cmp++; if (timeouts !== 0) begin n_fail++; $display("FAIL long_consumed: got %0d timeouts want 0", timeouts); end
      b = eg_q.size();
      send_pkt(8'd1, 15'd5, 1, 1'b0);
      settle();
      n_cmp++; if (eg_q.size() - b !== 1) begin n_fail++; $display("FAIL long_next_count: got %0d want 1", eg_q.size() - b); end
   endtask

   task automatic test_toggle();
      int b; int d0;
      b = eg_q.size(); d0 = drops;
      mirror_bad = 0; mirror_en = 1; tog = 1;
      send_pkt(8'd8, 15'd9, 8, 1'b1);
      mirror_en = 0;
      settle();
      n_cmp++; if (eg_q.size() - b !== 8) begin n_fail++; $display("FAIL tog_count: got %0d want 8", eg_q.size() - b); end
      for (int i = 0; i < 8 && b + i < eg_q.size(); i++) begin
         n_cmp++; if (eg_q[b+i].data !== pay(9, i + 1)) begin n_fail++; $display("FAIL tog_data[%0d]: got %h want %h", i, eg_q[b+i].data, pay(9, i + 1)); end
         n_cmp++; if (eg_q[b+i].dest !== 5'd31 || eg_q[b+i].last !== (i == 7)) begin n_fail++; $display("FAIL tog_beat[%0d]: got dest=%0d last=%b want dest=31 last=%b", i, eg_q[b+i].dest, eg_q[b+i].last, i == 7); end
      end
      n_cmp++; if (mirror_bad !== 0) begin n_fail++; $display("FAIL tog_mirror: got %0d mismatching cycles want 0", mirror_bad); end
      n_cmp++; if (drops - d0 !== 0) begin n_fail++; $display("FAIL tog_drops: got %0d want 0", drops - d0); end
   endtask

   task automatic test_back_to_back();
      int b; int pay_acc; int hdr_acc;
      b = eg_q.size();
      send_pkt(8'd2, 15'd5, 2, 1'b0);
      pay_acc = last_acc;
      drive_beat({8'd1, 9'd0, 15'd9}, 16'h0, 1'b0, 1'b0);
      hdr_acc = last_acc;
      drive_beat(pay(9, 1), pusr(1), 1'b1, 1'b0);
      settle();
      n_cmp++; if (hdr_acc !== pay_acc + 1) begin n_fail++; $display("FAIL b2b_hdr_cycle: got %0d want %0d", hdr_acc, pay_acc + 1); end
      n_cmp++; if (eg_q.size() - b !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", eg_q.size() - b); end
      if (eg_q.size() - b >= 3) begin
         n_cmp++; if (eg_q[b+2].dest !== 5'd31 || eg_q[b+2].data !== pay(9, 1)) begin n_fail++; $display("FAIL b2b_second: got dest=%0d data=%h want dest=31 data=%h", eg_q[b+2].dest, eg_q[b+2].data, pay(9, 1)); end
      end
   endtask

   task automatic test_reset_mid();
      int b;
      drive_beat({8'd8, 9'd0, 15'd5}, 16'h0, 1'b0, 1'b0);
      drive_beat(pay(5, 1), pusr(1), 1'b0, 1'b0);
      drive_beat(pay(5, 2), pusr(2), 1'b0, 1'b0);
      s_if.tvalid = 1'b1; s_if.tdata = pay(5, 3); s_if.tuser = pusr(3); m_if.tready = 1'b1;
      #2;
      n_cmp++; if (m_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_tvalid: got %b want 1", m_if.tvalid); end
      reset_n = 1'b0;
      #1;
      n_cmp++; if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hs: got tvalid=%b tready=%b want 0 0", m_if.tvalid, s_if.tready); end
      n_cmp++; if (m_if.tdata !== 32'h0 || m_if.tlast !== 1'b0 || m_if.tdest !== 5'd0) begin n_fail++; $display("FAIL mid_rst_out: got data=%h last=%b dest=%0d want 0 0 0", m_if.tdata, m_if.tlast, m_if.tdest); end
      s_if.tvalid = 1'b0;
      @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      b = eg_q.size();
      send_pkt(8'd2, 15'd5, 2, 1'b0);
      settle();
      n_cmp++; if (eg_q.size() - b !== 2) begin n_fail++; $display("FAIL mid_next_count: got %0d want 2", eg_q.size() - b); end
      if (eg_q.size() - b >= 2) begin
         n_cmp++; if (eg_q[b].data !== pay(5, 1) || eg_q[b].dest !== 5'd3) begin n_fail++; $display("FAIL mid_next_beat1: got data=%h dest=%0d want %h 3", eg_q[b].data, eg_q[b].dest, pay(5, 1)); end
         n_cmp++; if (eg_q[b+1].last !== 1'b1 || eg_q[b+1].user !== pusr(2)) begin n_fail++; $display("FAIL mid_next_beat2: got last=%b user=%h want 1 %h", eg_q[b+1].last, eg_q[b+1].user, pusr(2)); end
      end
`ifdef PARSER_DROP_CNT_EN
      for (int k = 0; k < 3; k++) send_pkt(8'd1, 15'd7, 1, 1'b0);
      settle();
      n_cmp++; if (drop_cnt !== 16'd3) begin n_fail++; $display("FAIL drop_cnt: got %0d want 3", drop_cnt); end
`endif
   endtask

   initial begin
      for (int a = 0; a < 32768; a++) cfg_mem[a] = 32'h0;
      cfg_mem[5] = 32'h8000_0003;
      cfg_mem[7] = 32'h0000_0001;
      cfg_mem[9] = 32'h8000_001F;
      test_reset();
      test_valid();
      test_invalid();
      test_short();
      test_long();
      test_toggle();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
